// File: rtl/i2s_tx.sv
// I2S transmitter: latches one stereo pair per frame, serialises it MSB-first
// with BCLK/LRCLK derived from clk, and pulses sample_req on each latch.
//
// Ports:
//   clk, reset_n           system clock, async active-low reset
//   en                     run request, sampled at frame boundaries
//   sample_l_i, sample_r_i signed samples, captured at frame boundaries
//   bclk, lrclk, sdata     I2S bus (sdata/lrclk change on BCLK falling events)
//   sample_req             one-cycle pulse when the hold registers load
//   tone_i                 test-tone select (only with I2S_TX_TONE_EN)
//
// Optional feature macro: I2S_TX_TONE_EN adds a square-wave test tone
// (+/-TONE_AMP, sign flipping every TONE_HALF frames) selected by tone_i.
module i2s_tx #(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 16,
`ifdef I2S_TX_TONE_EN
   parameter int TONE_HALF = 24,
   parameter logic signed [DATA_W-1:0] TONE_AMP = 16'sd8192,
`endif
   parameter int SLOT_W  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
`ifdef I2S_TX_TONE_EN
   input  logic              tone_i,
`endif
   input  logic [DATA_W-1:0] sample_l_i,
   input  logic [DATA_W-1:0] sample_r_i,
   output logic              bclk,
   output logic              lrclk,
   output logic              sdata,
   output logic              sample_req
);

   localparam int FRAME = 2 * SLOT_W;
   localparam int BW    = $clog2(FRAME);
   localparam int DCW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);
   localparam logic [BW-1:0]  BIT_LAST = BW'(FRAME - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic [DCW-1:0]    div_cnt;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] hold_l, hold_r;
   logic [DATA_W-1:0] load_l, load_r;

   logic tick, fall, wrap, load, stop;

   logic [BW-1:0]     bit_nxt, k;
   logic              lr_nxt, sd_nxt;
   logic [DATA_W-1:0] word, sh;

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (en)   state_d = RUN;
         RUN:     if (stop) state_d = IDLE;
         default:           state_d = IDLE;
      endcase
   end

   // control strobes
   always_comb begin
      tick = 1'b0;
      fall = 1'b0;
      wrap = 1'b0;
      load = 1'b0;
      stop = 1'b0;
      if (state_q == RUN) begin
         tick = (div_cnt == DIV_LAST);
         fall = tick && bclk;
         wrap = fall && (bit_cnt == BIT_LAST);
         load = wrap && en;
         stop = wrap && !en;
      end
   end

   // next bit position and the data bit it carries
   always_comb begin
      bit_nxt = wrap ? '0 : bit_cnt + BW'(1);
      lr_nxt  = (bit_nxt >= BW'(SLOT_W));
      k       = lr_nxt ? bit_nxt - BW'(SLOT_W) : bit_nxt;
      word    = lr_nxt ? hold_r : hold_l;
      sh      = word << (k - BW'(1));
      sd_nxt  = 1'b0;
      if (k != '0 && k <= BW'(DATA_W)) sd_nxt = sh[DATA_W-1];
   end

`ifdef I2S_TX_TONE_EN
   localparam int TCW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

   logic [TCW-1:0]    tone_cnt;
   logic              tone_neg;
   logic [DATA_W-1:0] tone_val;

   assign tone_val = tone_neg ? -TONE_AMP : TONE_AMP;
   assign load_l   = tone_i ? tone_val : sample_l_i;
   assign load_r   = tone_i ? tone_val : sample_r_i;

   // counts tone frames; sign flips after TONE_HALF loads
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tone_cnt <= '0;
         tone_neg <= 1'b0;
      end else if (state_q == IDLE || !tone_i) begin
         tone_cnt <= '0;
         tone_neg <= 1'b0;
      end else if (load) begin
         if (tone_cnt == TCW'(TONE_HALF - 1)) begin
            tone_cnt <= '0;
            tone_neg <= ~tone_neg;
         end else begin
            tone_cnt <= tone_cnt + TCW'(1);
         end
      end
   end
`else
   assign load_l = sample_l_i;
   assign load_r = sample_r_i;
`endif

   // datapath; IDLE and the stopping boundary force reset values
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt    <= '0;
         bit_cnt    <= BIT_LAST;
         bclk       <= 1'b0;
         lrclk      <= 1'b1;
         sdata      <= 1'b0;
         sample_req <= 1'b0;
         hold_l     <= '0;
         hold_r     <= '0;
      end else if (state_q == IDLE || stop) begin
         div_cnt    <= '0;
         bit_cnt    <= BIT_LAST;
         bclk       <= 1'b0;
         lrclk      <= 1'b1;
         sdata      <= 1'b0;
         sample_req <= 1'b0;
         hold_l     <= '0;
         hold_r     <= '0;
      end else begin
         sample_req <= load;
         if (tick) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
         end else begin
            div_cnt <= div_cnt + DCW'(1);
         end
         if (fall) begin
            bit_cnt <= bit_nxt;
            lrclk   <= lr_nxt;
            sdata   <= sd_nxt;
         end
         if (load) begin
            hold_l <= load_l;
            hold_r <= load_r;
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: timing-arithmetic reference model checked
// every cycle, plus literal frame/pulse-spacing expectations.
module tb_i2s_tx;

   localparam int CD    = 4;
   localparam int DW    = 16;
   localparam int SW    = 32;
   localparam int FALL  = 2 * CD;
   localparam int FRM   = 4 * SW * CD;
   localparam int TH    = 24;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          en = 1'b0;
   logic          tone_i = 1'b0;
   logic [DW-1:0] sl = '0, sr = '0;
   logic          bclk, lrclk, sdata, sample_req;

   int n_run = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   i2s_tx dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en),
`ifdef I2S_TX_TONE_EN
      .tone_i     (tone_i),
`endif
      .sample_l_i (sl),
      .sample_r_i (sr),
      .bclk       (bclk),
      .lrclk      (lrclk),
      .sdata      (sdata),
      .sample_req (sample_req)
   );

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // reference model: time since entering RUN plus the latched pair
   bit            m_run = 1'b0;
   int            t = 0;
   int            m_tf = 0;
   logic [DW-1:0] m_l = '0, m_r = '0;

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         m_run = 1'b0;
         t = 0;
         m_tf = 0;
      end else if (!m_run) begin
         m_tf = 0;
         if (en) begin
            m_run = 1'b1;
            t = 0;
         end
      end else begin
         if (!tone_i) m_tf = 0;
         t++;
         if (t >= FALL && (t - FALL) % FRM == 0) begin
            if (!en) begin
               m_run = 1'b0;
               t = 0;
            end else begin
               m_l = sl;
               m_r = sr;
`ifdef I2S_TX_TONE_EN
               if (tone_i) begin
                  m_l = ((m_tf / TH) % 2 == 0) ? 16'h2000 : 16'hE000;
                  m_r = m_l;
                  m_tf++;
               end
`endif
            end
         end
      end
   end

   // per-cycle compare against the model
   initial forever begin
      logic e_bc, e_lr, e_sd, e_sr;
      logic [DW-1:0] hw;
      int n, b, k;
      @(negedge clk);
      if (chk_en) begin
         e_bc = 1'b0; e_lr = 1'b1; e_sd = 1'b0; e_sr = 1'b0;
         if (m_run) begin
            e_bc = ((t / CD) % 2) == 1;
            n = t / FALL;
            if (n > 0) begin
               b = (n - 1) % (2 * SW);
               e_lr = (b >= SW);
               k = b % SW;
               hw = e_lr ? m_r : m_l;
               if (k >= 1 && k <= DW) e_sd = hw[DW-k];
            end
            e_sr = (t >= FALL) && ((t - FALL) % FRM == 0);
         end
         check("bclk", 64'(bclk), 64'(e_bc));
         check("lrclk", 64'(lrclk), 64'(e_lr));
         check("sdata", 64'(sdata), 64'(e_sd));
         check("sample_req", 64'(sample_req), 64'(e_sr));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!sample_req && n < budget);
      if (!sample_req) check("req_timeout", 64'(n), 64'(0));
   endtask

   // called right after a boundary edge; samples the 64 bits of that frame
   task automatic grab(input int chg_bit, input logic [DW-1:0] nl,
                       input logic [DW-1:0] nr,
                       output logic [63:0] w, output int lr_cnt);
      lr_cnt = 0;
      w = '0;
      for (int b = 0; b < 64; b++) begin
         repeat ((b == 0) ? 4 : 8) step();
         w[63-b] = sdata;
         if (lrclk) lr_cnt++;
         if (b == chg_bit) begin
            sl = nl;
            sr = nr;
         end
      end
   endtask

   function automatic logic [63:0] fw(input logic [DW-1:0] l,
                                      input logic [DW-1:0] r);
      return {1'b0, l, 15'h0, 1'b0, r, 15'h0};
   endfunction

   initial begin
      #(10 * 95000);
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n, cnt, lrc;
      logic [63:0] w;
      #2 reset_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) step();
      reset_n = 1'b1;

      // idle for 1000 clk
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (sample_req) cnt++;
      end
      check("idle_req_count", 64'(cnt), 64'(0));
      check("idle_bclk", 64'(bclk), 64'(0));
      check("idle_lrclk", 64'(lrclk), 64'(1));

      // first frame
      sl = 16'hA5C3;
      sr = 16'h5A3C;
      en = 1'b1;
      step();
      wait_req(20, n);
      check("first_req_clk", 64'(n), 64'(8));
      grab(-1, sl, sr, w, lrc);
      check("frame0", w, fw(16'hA5C3, 16'h5A3C));
      check("frame0_lr_bclks", 64'(lrc), 64'(32));

      // inputs change mid-frame at bit 40
      wait_req(20, n);
      check("req_spacing", 64'(508 + n), 64'(FRM));
      grab(40, 16'h1234, 16'hFEDC, w, lrc);
      check("frame1_unchanged", w, fw(16'hA5C3, 16'h5A3C));
      wait_req(20, n);
      grab(-1, sl, sr, w, lrc);
      check("frame2_new", w, fw(16'h1234, 16'hFEDC));

      // en drop at bit 10
      wait_req(20, n);
      repeat (4 + 8 * 10) step();
      en = 1'b0;
      cnt = 0;
      for (int i = 0; i < 700; i++) begin
         step();
         if (sample_req) cnt++;
      end
      check("drop_req_count", 64'(cnt), 64'(0));
      check("drop_lrclk", 64'(lrclk), 64'(1));

      // async reset at bit 20
      en = 1'b1;
      step();
      wait_req(20, n);
      repeat (4 + 8 * 20) step();
      reset_n = 1'b0;
      #1;
      check("rst_bclk", 64'(bclk), 64'(0));
      check("rst_lrclk", 64'(lrclk), 64'(1));
      check("rst_sdata", 64'(sdata), 64'(0));
      check("rst_req", 64'(sample_req), 64'(0));
      repeat (2) step();
      reset_n = 1'b1;
      step();
      wait_req(20, n);
      check("rerun_req_clk", 64'(n), 64'(8));

      // randomized segments
      for (int s = 0; s < 16; s++) begin
         en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) begin
            reset_n = 1'b0;
            repeat (2) step();
            reset_n = 1'b1;
         end
         for (int i = $urandom_range(50, 1200); i > 0; i--) begin
            sl = DW'($urandom);
            sr = DW'($urandom);
            step();
         end
      end

`ifdef I2S_TX_TONE_EN
      en = 1'b0;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      tone_i = 1'b1;
      en = 1'b1;
      step();
      for (int f = 0; f < 50; f++) begin
         wait_req(600, n);
         if (f == 0 || f == 24 || f == 48) begin
            grab(-1, sl, sr, w, lrc);
            if (f == 24) check("tone_neg", w, fw(16'hE000, 16'hE000));
            else         check("tone_pos", w, fw(16'h2000, 16'h2000));
         end
      end
      tone_i = 1'b0;
`endif

      en = 1'b0;
      repeat (1200) step();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
